change_dispenser: RTL

- Payout side of the vending datapath. The coin acceptor and FSM take coins in; this block pays change out.
- Takes a change amount in 10-unit steps and issues coins one at a time to the ejector mechanism over a valid/ready handshake.
- Uses the shared coin encoding: 2'b00 = 10, 2'b01 = 20, 2'b10 = 50.
- Selection is greedy, bounded by an on-board per-denomination stock count.

---
 rtl/vending_pkg.sv | 37 +++
 rtl/coin_stock.sv | 65 ++++++
 rtl/change_dispenser.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the vending datapath (coin acceptor FSM and change
// dispenser):
//   - coin encoding constants COIN_10 / COIN_20 / COIN_50
//   - value of each coin in units of 10 (1, 2, 5)
//   - dispenser FSM state type
//   - coin_units(): maps a coin code to its value in units of 10
// -----------------------------------------------------------------------------
package vending_pkg;

  localparam logic [1:0] COIN_10 = 2'b00;
  localparam logic [1:0] COIN_20 = 2'b01;
  localparam logic [1:0] COIN_50 = 2'b10;

  localparam logic [2:0] UNITS_10 = 3'd1;
  localparam logic [2:0] UNITS_20 = 3'd2;
  localparam logic [2:0] UNITS_50 = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_DONE,
    ST_FAULT
  } disp_state_e;

  // The unused code 2'b11 maps to the smallest value; it is never issued.
  function automatic logic [2:0] coin_units(input logic [1:0] coin);
    case (coin)
      COIN_50: coin_units = UNITS_50;
      COIN_20: coin_units = UNITS_20;
      default: coin_units = UNITS_10;
    endcase
  endfunction

endpackage

// File: rtl/coin_stock.sv
// -----------------------------------------------------------------------------
// coin_stock
// Per-denomination stock counters for the change dispenser. One saturating
// counter per coin (index = coin code: 0 -> 10, 1 -> 20, 2 -> 50).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset; all stocks -> INIT_STOCK
//   load_en    in   refill strobe
//   load_coin  in   denomination to refill (2'b11 is ignored)
//   load_count in   coins added by the refill
//   dec_en     in   one coin of dec_coin has left the machine
//   dec_coin   in   denomination being decremented
//   nonzero    out  per-denomination "stock != 0" flags
// -----------------------------------------------------------------------------
module coin_stock
  import vending_pkg::*;
#(
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [1:0]         load_coin,
  input  logic [STOCK_W-1:0] load_count,
  input  logic               dec_en,
  input  logic [1:0]         dec_coin,
  output logic [2:0]         nonzero
);

  localparam logic [STOCK_W:0] STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};

  logic [2:0][STOCK_W-1:0] stock_q;
  logic [2:0][STOCK_W-1:0] stock_d;

  // The sum is formed one bit wider so that refill overflow can be clamped.
  // A decrement only happens on a nonzero counter, so it cannot wrap below 0,
  // and a simultaneous refill and decrement nets to stock + count - 1.
  always_comb begin
    logic [STOCK_W:0] sum;
    stock_d = stock_q;
    for (int i = 0; i < 3; i++) begin
      sum = {1'b0, stock_q[i]};
      if (load_en && (load_coin == 2'(i))) sum = sum + {1'b0, load_count};
      if (dec_en && (dec_coin == 2'(i)))   sum = sum - 1'b1;
      stock_d[i] = (sum > STOCK_MAX) ? STOCK_MAX[STOCK_W-1:0] : sum[STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stock_q <= {3{STOCK_W'(INIT_STOCK)}};
    end else begin
      stock_q <= stock_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nonzero[i] = (stock_q[i] != '0);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Payout side of the vending datapath. Takes a change amount (units of 10) and
// issues coins one at a time to the ejector over a valid/ready handshake,
// choosing greedily (50, 20, 10) among denominations that are in stock.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   request a payout (sampled in IDLE or FAULT only)
//   amount       in   change to pay, units of 10, sampled with start
//   coin_out     out  denomination being issued (COIN_10/20/50)
//   coin_valid   out  coin_out is waiting for the ejector
//   coin_ready   in   ejector accepts the coin (transfer on valid && ready)
//   load_en      in   refill strobe
//   load_coin    in   denomination to refill (2'b11 ignored)
//   load_count   in   coins added by the refill (saturating)
//   busy         out  payout in progress (SELECT or ISSUE)
//   done         out  one-cycle pulse on payout completion
//   short_fault  out  payout could not complete; held until next start
//   remaining    out  unpaid amount (the shortfall while faulted)
//
// Optional build macro PAYOUT_STATS_EN adds:
//   coins_paid   out  coins accepted by the ejector since reset (wrapping)
//   fault_count  out  FAULT entries since reset (saturating at 255)
// -----------------------------------------------------------------------------
module change_dispenser
  import vending_pkg::*;
#(
  parameter int AMT_W      = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [AMT_W-1:0]   amount,
  output logic [1:0]         coin_out,
  output logic               coin_valid,
  input  logic               coin_ready,
  input  logic               load_en,
  input  logic [1:0]         load_coin,
  input  logic [STOCK_W-1:0] load_count,
  output logic               busy,
  output logic               done,
  output logic               short_fault,
`ifdef PAYOUT_STATS_EN
  output logic [15:0]        coins_paid,
  output logic [7:0]         fault_count,
`endif
  output logic [AMT_W-1:0]   remaining
);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       coin_q, coin_d;
  logic [2:0]       stock_nz;
  logic             accept;

  assign accept = (state_q == ST_ISSUE) && coin_ready;

  coin_stock #(
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_coin  (load_coin),
    .load_count (load_count),
    .dec_en     (accept),
    .dec_coin   (coin_q),
    .nonzero    (stock_nz)
  );

  // Next-state, coin selection and remaining-amount update. A coin is only
  // picked when its value fits in remaining, so the subtraction in ISSUE can
  // never underflow. The greedy pick is never revisited.
  always_comb begin
    logic [AMT_W-1:0] after_coin;
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    after_coin  = remaining_q - AMT_W'(coin_units(coin_q));

    case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (start) begin
          remaining_d = amount;
          state_d     = (amount == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: begin
        if ((remaining_q >= AMT_W'(UNITS_50)) && stock_nz[COIN_50]) begin
          coin_d  = COIN_50;
          state_d = ST_ISSUE;
        end else if ((remaining_q >= AMT_W'(UNITS_20)) && stock_nz[COIN_20]) begin
          coin_d  = COIN_20;
          state_d = ST_ISSUE;
        end else if ((remaining_q >= AMT_W'(UNITS_10)) && stock_nz[COIN_10]) begin
          coin_d  = COIN_10;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_ISSUE: begin
        if (coin_ready) begin
          remaining_d = after_coin;
          state_d     = (after_coin == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      coin_q      <= COIN_10;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
    end
  end

  // Status outputs decode the state directly, so an asynchronous reset drops
  // coin_valid immediately and the pending coin is never counted.
  assign coin_out    = coin_q;
  assign coin_valid  = (state_q == ST_ISSUE);
  assign busy        = (state_q == ST_SELECT) || (state_q == ST_ISSUE);
  assign done        = (state_q == ST_DONE);
  assign short_fault = (state_q == ST_FAULT);
  assign remaining   = remaining_q;

`ifdef PAYOUT_STATS_EN
  logic [15:0] coins_paid_q, coins_paid_d;
  logic [7:0]  fault_count_q, fault_count_d;

  // Fault entries are only ever made from SELECT.
  always_comb begin
    coins_paid_d  = coins_paid_q;
    fault_count_d = fault_count_q;
    if (accept) coins_paid_d = coins_paid_q + 16'd1;
    if ((state_q == ST_SELECT) && (state_d == ST_FAULT) && (fault_count_q != 8'hFF)) begin
      fault_count_d = fault_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coins_paid_q  <= '0;
      fault_count_q <= '0;
    end else begin
      coins_paid_q  <= coins_paid_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign coins_paid  = coins_paid_q;
  assign fault_count = fault_count_q;
`endif

endmodule
